// File: rtl/ahb_burst_sequencer.sv
// AHB master-side burst command engine: expands one burst command into
// address/control/write-data phases for top_ahb and returns read data per beat.
module ahb_burst_sequencer #(
    parameter int AW   = 32,   // must be >= 10 (1KB boundary check)
    parameter int DW   = 32,
    parameter int LENW = 8     // must be >= 4 so a 16-beat count fits
) (
    input  logic            clk,
    input  logic            hreset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [AW-1:0]   cmd_addr,
    input  logic            cmd_write,
    input  logic [2:0]      cmd_hsize,
    input  logic [2:0]      cmd_hburst,
    input  logic [1:0]      cmd_hsel,
    input  logic [LENW-1:0] cmd_len,
    input  logic            wd_valid,
    input  logic [DW-1:0]   wd_data,
    output logic            wd_ready,
    input  logic            hready,
    input  logic            hresp,
    input  logic [DW-1:0]   hrdata,
    output logic            enable,
    output logic [AW-1:0]   in_haddr,
    output logic [1:0]      in_htrans,
    output logic            in_hwrite,
    output logic [2:0]      in_hsize,
    output logic [2:0]      in_hburst,
    output logic [1:0]      in_hsel,
    output logic [DW-1:0]   in_hwdata,
    output logic            rd_valid,
    output logic [DW-1:0]   rd_data,
    output logic            done,
    output logic            err
);
    localparam int CW = LENW + 1;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_DONE} state_t;
    state_t state_q, state_d;

    logic [AW-1:0] addr_q, addr_nxt, addr_inc, incr, wrap_b;
    logic          write_q;
    logic [2:0]    hsize_q, hburst_q;
    logic [1:0]    hsel_q;
    logic [CW-1:0] beats_q, cnt_q, cmd_beats;
    logic [DW-1:0] hwdata_q, rd_data_q;
    logic          dphase_q, err_q, rd_valid_q;
    logic          cmd_acc, beat_acc, err_now, is_wrap;
    logic [1:0]    trans;

    // Beat count implied by the incoming command
    always_comb begin
        case (cmd_hburst)
            3'b000:         cmd_beats = CW'(1);
            3'b001:         cmd_beats = (cmd_len == '0) ? CW'(1) : CW'(cmd_len);
            3'b010, 3'b011: cmd_beats = CW'(4);
            3'b100, 3'b101: cmd_beats = CW'(8);
            default:        cmd_beats = CW'(16);
        endcase
    end

    // Odd hburst codes are incrementing, even non-zero codes wrap at beats*size
    assign is_wrap  = (hburst_q != 3'b000) && !hburst_q[0];
    assign incr     = AW'(1) << hsize_q;
    assign wrap_b   = AW'(beats_q) << hsize_q;
    assign addr_inc = addr_q + incr;
    assign addr_nxt = is_wrap ? ((addr_q & ~(wrap_b - AW'(1))) | (addr_inc & (wrap_b - AW'(1))))
                              : addr_inc;

    assign cmd_acc = (state_q == S_IDLE) && cmd_valid;
    // An ERROR response completes the data phase; the beat presented alongside it is dropped
    assign err_now = dphase_q && hready && hresp;

    // State register
    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, address-phase transfer type and beat acceptance
    always_comb begin
        state_d  = state_q;
        trans    = T_IDLE;
        beat_acc = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_valid) state_d = S_ADDR;
            S_ADDR: begin
                trans = (write_q && !wd_valid) ? T_IDLE : T_NONSEQ;
                if (hready && trans == T_NONSEQ) begin
                    beat_acc = 1'b1;
                    state_d  = (beats_q == CW'(1)) ? S_LAST : S_BURST;
                end
            end
            S_BURST: begin
                if (write_q && !wd_valid)                      trans = T_BUSY;
                else if (hburst_q[0] && addr_q[9:0] == 10'd0)  trans = T_NONSEQ;
                else                                           trans = T_SEQ;
                if (err_now) begin
                    state_d = S_DONE;
                end else if (hready && trans != T_BUSY) begin
                    beat_acc = 1'b1;
                    if (cnt_q + CW'(1) == beats_q) state_d = S_LAST;
                end
            end
            S_LAST:  if (hready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Burst fields, address/counter advance, write data capture and data-phase tracking
    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            hsize_q  <= '0;
            hburst_q <= '0;
            hsel_q   <= '0;
            beats_q  <= '0;
            cnt_q    <= '0;
            hwdata_q <= '0;
            dphase_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (cmd_acc) begin
                addr_q   <= cmd_addr;
                write_q  <= cmd_write;
                hsize_q  <= cmd_hsize;
                hburst_q <= cmd_hburst;
                hsel_q   <= cmd_hsel;
                beats_q  <= cmd_beats;
                cnt_q    <= '0;
                err_q    <= 1'b0;
            end else if (beat_acc) begin
                addr_q <= addr_nxt;
                cnt_q  <= cnt_q + CW'(1);
                if (write_q) hwdata_q <= wd_data;
            end
            if (hready)  dphase_q <= beat_acc;
            if (err_now) err_q    <= 1'b1;
        end
    end

    // Read data return; data from an ERROR beat is not reported
    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= dphase_q && hready && !hresp && !write_q;
            if (dphase_q && hready && !hresp && !write_q) rd_data_q <= hrdata;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign enable    = (state_q == S_ADDR) || (state_q == S_BURST) || (state_q == S_LAST);
    assign wd_ready  = beat_acc && write_q;
    assign in_haddr  = addr_q;
    assign in_htrans = trans;
    assign in_hwrite = write_q;
    assign in_hsize  = hsize_q;
    assign in_hburst = hburst_q;
    assign in_hsel   = hsel_q;
    assign in_hwdata = hwdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = (state_q == S_DONE);
    assign err       = done && err_q;

endmodule

// File: tb/tb_ahb_burst_sequencer.sv
// Bench for ahb_burst_sequencer: acts as AHB slave and write-data source,
// compares observed beats against a transaction-level burst model.
module tb_ahb_burst_sequencer;
    localparam int AW = 32, DW = 32, LENW = 8;

    logic clk = 1'b0, hreset;
    logic cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [2:0] cmd_hsize, cmd_hburst;
    logic [1:0] cmd_hsel;
    logic [LENW-1:0] cmd_len;
    logic wd_valid, wd_ready, hready, hresp;
    logic [DW-1:0] wd_data, hrdata;
    logic enable, in_hwrite, rd_valid, done, err;
    logic [AW-1:0] in_haddr;
    logic [1:0] in_htrans, in_hsel;
    logic [2:0] in_hsize, in_hburst;
    logic [DW-1:0] in_hwdata, rd_data;

    always #5 clk = ~clk;

    ahb_burst_sequencer #(.AW(AW), .DW(DW), .LENW(LENW)) dut (
        .clk(clk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_hsize(cmd_hsize),
        .cmd_hburst(cmd_hburst), .cmd_hsel(cmd_hsel), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
        .hready(hready), .hresp(hresp), .hrdata(hrdata), .enable(enable),
        .in_haddr(in_haddr), .in_htrans(in_htrans), .in_hwrite(in_hwrite),
        .in_hsize(in_hsize), .in_hburst(in_hburst), .in_hsel(in_hsel),
        .in_hwdata(in_hwdata), .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .err(err)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [1:0]  hsel;
        logic [7:0]  len;
        logic [31:0] addr;
    } cmd_t;

    typedef struct {
        cmd_t             c;
        int               nb;
        logic [3:0][31:0] a;
        logic [3:0][1:0]  t;
    } vec_t;

    int checks = 0, failures = 0;

    // driving knobs for run_burst
    int rdy_pct, wdv_pct, err_beat, busy_after, busy_len, stall_at;
    // observations of the last burst
    logic [31:0] got_addr[$];
    logic [1:0]  got_trans[$];
    logic [31:0] src[$];
    int busy_cnt, pops, done_cyc;
    logic got_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---- reference model: burst arithmetic straight from the protocol rules ----
    function automatic int beats_of(input logic [2:0] hb, input logic [7:0] len);
        case (hb)
            3'b000:         return 1;
            3'b001:         return (len == 8'd0) ? 1 : int'(len);
            3'b010, 3'b011: return 4;
            3'b100, 3'b101: return 8;
            default:        return 16;
        endcase
    endfunction

    function automatic bit is_wrap_type(input logic [2:0] hb);
        return (hb == 3'b010) || (hb == 3'b100) || (hb == 3'b110);
    endfunction

    function automatic logic [31:0] model_addr(input cmd_t c, input int nb, input int k);
        longint incr, b, base, start;
        incr  = longint'(1) << c.hsize;
        start = longint'(c.addr);
        if (is_wrap_type(c.hburst)) begin
            b    = longint'(nb) * incr;
            base = (start / b) * b;
            return 32'(base + ((start - base) + longint'(k) * incr) % b);
        end
        return 32'(start + longint'(k) * incr);
    endfunction

    function automatic logic [1:0] model_trans(input cmd_t c, input int k, input logic [31:0] a);
        if (k == 0) return 2'b10;
        if (!is_wrap_type(c.hburst) && (a % 1024) == 0) return 2'b10;
        return 2'b11;
    endfunction

    task automatic set_knobs(input int r, input int w, input int e, input int ba, input int bl, input int st);
        rdy_pct = r; wdv_pct = w; err_beat = e; busy_after = ba; busy_len = bl; stall_at = st;
    endtask

    // Issue one command, play slave + data source until done, then compare with the model.
    task automatic run_burst(input cmd_t c);
        int nb, acc, dph_idx, new_idx, busy_left, n_exp, n_rd;
        bit dph, new_dph, fin, err_now, prev_frz, want_idle, busy_done, exp_err;
        logic [31:0] prev_addr;
        logic [31:0] exp_rd[$];
        logic [31:0] got_rd[$];
        nb = beats_of(c.hburst, c.len);
        while (src.size() < nb) src.push_back($urandom);
        got_addr.delete(); got_trans.delete();
        busy_cnt = 0; pops = 0; done_cyc = -1; got_err = 1'b0;
        acc = 0; dph = 0; dph_idx = 0; fin = 0; prev_frz = 0; want_idle = 0;
        busy_left = 0; busy_done = 0; prev_addr = '0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                cmd_valid = 1'b1; cmd_write = c.wr; cmd_hsize = c.hsize; cmd_hburst = c.hburst;
                cmd_hsel = c.hsel; cmd_len = c.len; cmd_addr = c.addr;
            end else begin
                // stray command traffic while busy must be ignored
                cmd_valid = 1'($urandom_range(1)); cmd_write = 1'($urandom_range(1));
                cmd_hsize = 3'($urandom_range(7)); cmd_hburst = 3'($urandom_range(7));
                cmd_hsel = 2'($urandom_range(3)); cmd_len = 8'($urandom); cmd_addr = $urandom;
            end
            hready = ($urandom_range(99) < rdy_pct) && (cyc != stall_at);
            if (!busy_done && busy_len > 0 && acc == busy_after) begin
                busy_left = busy_len; busy_done = 1;
            end
            if (busy_left > 0) begin
                wd_valid = 1'b0; busy_left--;
            end else begin
                wd_valid = ($urandom_range(99) < wdv_pct);
            end
            wd_data = (pops < nb) ? src[pops] : 32'hDEAD_0000;
            hresp   = dph && (dph_idx == err_beat) && hready;
            hrdata  = $urandom;
            #1;
            if (cyc == 0) check("cmd_ready_idle", cmd_ready, 1);
            if (prev_frz) check("addr_frozen", in_haddr, prev_addr);
            if (want_idle) begin
                check("idle_after_err", in_htrans, 2'b00);
                want_idle = 0;
            end
            err_now = dph && hready && hresp;
            if (dph && hready) begin
                if (c.wr) check("hwdata", in_hwdata, src[dph_idx]);
                else if (!hresp) exp_rd.push_back(hrdata);
            end
            if (in_htrans == 2'b01) busy_cnt++;
            new_dph = 0; new_idx = 0;
            if (in_htrans[1] && hready && !err_now) begin
                got_addr.push_back(in_haddr);
                got_trans.push_back(in_htrans);
                check("attrs", {in_hwrite, in_hsize, in_hburst, in_hsel},
                      {c.wr, c.hsize, c.hburst, c.hsel});
                new_dph = 1; new_idx = acc; acc++;
            end
            if (hready) begin dph = new_dph; dph_idx = new_idx; end
            if (err_now) want_idle = 1;
            if (wd_ready) begin
                check("wd_ready_with_valid", wd_valid, 1);
                pops++;
            end
            if (rd_valid) got_rd.push_back(rd_data);
            prev_frz  = enable && (!hready || !in_htrans[1]);
            prev_addr = in_haddr;
            if (done) begin
                done_cyc = cyc; got_err = err; fin = 1;
                check("cmd_ready_in_done", cmd_ready, 0);
            end
        end
        check("done_seen", fin, 1);
        // cycle after done: still idle even though cmd_valid was high during done
        @(negedge clk);
        cmd_valid = 1'b0; hready = 1'b1; hresp = 1'b0; wd_valid = 1'b0;
        #1;
        check("idle_after_done", {enable, cmd_ready, rd_valid, done}, 4'b0100);

        exp_err = (err_beat >= 0) && (err_beat < nb);
        n_exp   = exp_err ? err_beat + 1 : nb;
        n_rd    = c.wr ? 0 : (exp_err ? err_beat : nb);
        check("beat_count", got_addr.size(), n_exp);
        for (int k = 0; k < got_addr.size() && k < n_exp; k++) begin
            check("beat_addr", got_addr[k], model_addr(c, nb, k));
            check("beat_trans", got_trans[k], model_trans(c, k, model_addr(c, nb, k)));
        end
        check("wd_pops", pops, c.wr ? n_exp : 0);
        check("rd_count", got_rd.size(), n_rd);
        for (int k = 0; k < got_rd.size() && k < exp_rd.size(); k++)
            check("rd_data", got_rd[k], exp_rd[k]);
        check("err_flag", got_err, exp_err);
        if (rdy_pct == 100 && wdv_pct == 100 && busy_len == 0 && stall_at < 0 && !exp_err)
            check("latency", done_cyc, nb + 2);
        src.delete();
    endtask

    function automatic vec_t mkv(input logic wr, input logic [2:0] hs, input logic [2:0] hb,
                                 input logic [7:0] len, input logic [31:0] addr, input int nb,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input logic [31:0] a3,
                                 input logic [7:0] tr);
        vec_t v;
        v.c.wr = wr; v.c.hsize = hs; v.c.hburst = hb; v.c.hsel = 2'(nb); v.c.len = len; v.c.addr = addr;
        v.nb = nb;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.t[0] = tr[7:6]; v.t[1] = tr[5:4]; v.t[2] = tr[3:2]; v.t[3] = tr[1:0];
        return v;
    endfunction

    initial begin
        vec_t vecs[8];
        cmd_t c;
        int nd, nb;

        hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_hsize = '0;
        cmd_hburst = '0; cmd_hsel = '0; cmd_len = '0; wd_valid = 1'b0; wd_data = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctrl", {cmd_ready, enable, in_htrans, wd_ready, rd_valid, done, err}, 8'b1000_0000);
        check("rst_haddr", in_haddr, 0);
        check("rst_hwdata", in_hwdata, 0);
        check("rst_rdata", rd_data, 0);
        @(negedge clk);
        hreset = 1'b0;

        // directed table, no stalls
        vecs[0] = mkv(1, 0, 3'b000, 0, 32'h1,   1,  32'h1,   0,       0,       0,       8'b10_00_00_00);
        vecs[1] = mkv(0, 2, 3'b011, 0, 32'h10,  4,  32'h10,  32'h14,  32'h18,  32'h1C,  8'b10_11_11_11);
        vecs[2] = mkv(1, 2, 3'b010, 0, 32'h38,  4,  32'h38,  32'h3C,  32'h30,  32'h34,  8'b10_11_11_11);
        vecs[3] = mkv(0, 2, 3'b001, 4, 32'h3F8, 4,  32'h3F8, 32'h3FC, 32'h400, 32'h404, 8'b10_11_10_11);
        vecs[4] = mkv(1, 1, 3'b001, 0, 32'h100, 1,  32'h100, 0,       0,       0,       8'b10_00_00_00);
        vecs[5] = mkv(0, 1, 3'b100, 0, 32'h0E,  8,  32'h0E,  32'h00,  32'h02,  32'h04,  8'b10_11_11_11);
        vecs[6] = mkv(1, 0, 3'b111, 0, 32'h3FE, 16, 32'h3FE, 32'h3FF, 32'h400, 32'h401, 8'b10_11_10_11);
        vecs[7] = mkv(0, 2, 3'b110, 0, 32'h7C,  16, 32'h7C,  32'h40,  32'h44,  32'h48,  8'b10_11_11_11);
        for (int i = 0; i < 8; i++) begin
            set_knobs(100, 100, -1, 0, 0, -1);
            src.delete();
            if (i == 0) src.push_back(32'hA5);
            run_burst(vecs[i].c);
            check("tbl_beats", got_addr.size(), vecs[i].nb);
            for (int k = 0; k < 4 && k < vecs[i].nb && k < got_addr.size(); k++) begin
                check("tbl_addr", got_addr[k], vecs[i].a[k]);
                check("tbl_trans", got_trans[k], vecs[i].t[k]);
            end
        end

        // INCR8 write: data source empty for 2 cycles after beat 3, one hready stall
        c = '{wr: 1'b1, hsize: 3'd2, hburst: 3'b101, hsel: 2'd1, len: 8'd0, addr: 32'h200};
        set_knobs(100, 100, -1, 3, 2, 7);
        run_burst(c);
        check("busy_cycles", busy_cnt, 2);

        // INCR16 read, ERROR on the fifth beat
        c = '{wr: 1'b0, hsize: 3'd2, hburst: 3'b111, hsel: 2'd2, len: 8'd0, addr: 32'h500};
        set_knobs(100, 100, 4, 0, 0, -1);
        run_burst(c);
        @(negedge clk); #1;
        check("ready_after_err", cmd_ready, 1);

        // reset in the middle of a burst
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_hsize = 3'd2; cmd_hburst = 3'b101;
        cmd_addr = 32'h300; hready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("midrst_running", enable, 1);
        hreset = 1'b1;
        #1;
        check("midrst_now", {enable, cmd_ready, in_htrans, done}, 5'b01000);
        check("midrst_haddr", in_haddr, 0);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) hreset = 1'b0;
            #1;
            if (done) nd++;
        end
        check("midrst_no_done", nd, 0);

        // randomized bursts with stalls, data gaps and occasional errors
        for (int i = 0; i < 40; i++) begin
            c.wr = 1'($urandom_range(1));
            c.hsize = 3'($urandom_range(2));
            c.hburst = 3'($urandom_range(7));
            c.hsel = 2'($urandom_range(3));
            c.len = 8'($urandom_range(20));
            if ($urandom_range(1) == 1) c.addr = $urandom;
            else c.addr = 32'h400 * $urandom_range(1, 8) - $urandom_range(0, 64);
            c.addr = c.addr & ~((32'd1 << c.hsize) - 32'd1);
            nb = beats_of(c.hburst, c.len);
            set_knobs($urandom_range(60, 100), $urandom_range(60, 100),
                      ($urandom_range(3) == 0) ? $urandom_range(0, nb + 1) : -1, 0, 0, -1);
            run_burst(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
